// File: rtl/fast_square_bb_comb_core_pkg.sv
// Shared constants and helpers for the baseband comb averager.
// Defaults match the fast-square receive chain; modules override via parameters.
package fast_square_bb_comb_core_pkg;
  localparam int PERIOD_DEF = 32;
  localparam int SHIFT_DEF  = 4;
  localparam int ACC_W      = 16 + SHIFT_DEF;
  localparam int IDX_W      = $clog2(PERIOD_DEF);
  localparam int SAT_IN_W   = 40;

  // Clamp a wide signed value into the 16-bit sample range.
  function automatic logic signed [15:0] sat16(input logic signed [SAT_IN_W-1:0] v);
    if (v > 40'sd32767) return 16'sh7FFF;
    else if (v < -40'sd32768) return 16'sh8000;
    else return v[15:0];
  endfunction
endpackage

// File: rtl/fast_square_bb_comb_core_slot_avg.sv
// One channel of the comb: per-slot leaky-integrator array with rounding and
// saturating output register. Same-slot read-modify-write happens in one cycle.
module comb_slot_avg
  import fast_square_bb_comb_core_pkg::*;
#(
  parameter int PERIOD = PERIOD_DEF,
  parameter int SHIFT  = SHIFT_DEF,
  parameter int IW     = (PERIOD > 1) ? $clog2(PERIOD) : 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [IW-1:0]      idx,
  input  logic               record,
  input  logic signed [15:0] x_in,
  output logic signed [15:0] x_out
);
  localparam int AW = 16 + SHIFT;
  localparam int WW = AW + 2;
  localparam logic signed [WW-1:0] HALF_W = WW'(2 ** (SHIFT - 1));
  localparam logic signed [AW:0]   HALF_R = (AW + 1)'(2 ** (SHIFT - 1));

  logic signed [AW-1:0] acc [PERIOD];
  logic signed [AW-1:0] a;
  logic signed [AW-1:0] x_ext;
  logic signed [AW-1:0] upd;
  logic signed [AW-1:0] v;
  logic signed [WW-1:0] a_w;
  logic signed [WW-1:0] x_w;
  logic signed [WW-1:0] delta;
  logic signed [WW-1:0] sum_w;
  logic signed [AW:0]   v_r;
  logic signed [AW:0]   rnd;
  logic signed [SAT_IN_W-1:0] rnd_w;
  logic signed [15:0]   x_next;

  always_comb begin
    a      = acc[idx];
    x_ext  = {x_in, {SHIFT{1'b0}}};
    // Two guard bits keep X - a + half exact before the arithmetic shift.
    a_w    = {{2{a[AW-1]}}, a};
    x_w    = {{2{x_ext[AW-1]}}, x_ext};
    delta  = (x_w - a_w + HALF_W) >>> SHIFT;
    sum_w  = a_w + delta;
    upd    = sum_w[AW-1:0];
    v      = record ? a : upd;
    v_r    = {v[AW-1], v};
    rnd    = (v_r + HALF_R) >>> SHIFT;
    rnd_w  = {{(SAT_IN_W - AW - 1){rnd[AW]}}, rnd};
    x_next = sat16(rnd_w);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < PERIOD; k++) acc[k] <= '0;
      x_out <= '0;
    end else begin
      if (!record) acc[idx] <= upd;
      x_out <= x_next;
    end
  end
endmodule

// File: rtl/fast_square_bb_comb_core.sv
// Baseband comb top: slot index with one-slot phase slip, period strobe,
// and two identical channel averagers for I and Q.
module fast_square_bb_comb_core
  import fast_square_bb_comb_core_pkg::*;
#(
  parameter int PERIOD = PERIOD_DEF,
  parameter int SHIFT  = SHIFT_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               freq_step,
  input  logic               record,
  input  logic signed [15:0] i_in,
  input  logic signed [15:0] q_in,
  output logic signed [15:0] i_out,
  output logic signed [15:0] q_out,
  output logic               data_out_strobe
);
  localparam int IW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  logic [IW-1:0] idx;
  logic [IW-1:0] idx_next;
  logic [IW:0]   sum;
  logic          wrap;

  // With PERIOD=2 and a slip every cycle, idx+2 wraps back onto itself.
  always_comb begin
    sum      = {1'b0, idx} + (freq_step ? (IW + 1)'(2) : (IW + 1)'(1));
    wrap     = (sum >= (IW + 1)'(PERIOD));
    idx_next = wrap ? IW'(sum - (IW + 1)'(PERIOD)) : IW'(sum);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      idx             <= '0;
      data_out_strobe <= 1'b0;
    end else begin
      idx             <= idx_next;
      data_out_strobe <= wrap;
    end
  end

  comb_slot_avg #(.PERIOD(PERIOD), .SHIFT(SHIFT), .IW(IW)) u_avg_i (
    .clock  (clock),
    .reset  (reset),
    .idx    (idx),
    .record (record),
    .x_in   (i_in),
    .x_out  (i_out)
  );

  comb_slot_avg #(.PERIOD(PERIOD), .SHIFT(SHIFT), .IW(IW)) u_avg_q (
    .clock  (clock),
    .reset  (reset),
    .idx    (idx),
    .record (record),
    .x_in   (q_in),
    .x_out  (q_out)
  );
endmodule

// File: tb/tb_fast_square_bb_comb_core.sv
// Bench for the comb averager at default parameters (PERIOD=32, SHIFT=4).
module tb_fast_square_bb_comb_core;
  localparam int P = 32;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               freq_step = 1'b0;
  logic               record = 1'b0;
  logic signed [15:0] i_in = '0;
  logic signed [15:0] q_in = '0;
  logic signed [15:0] i_out;
  logic signed [15:0] q_out;
  logic               data_out_strobe;

  int compared = 0;
  int mismatched = 0;

  logic [32:0] exp_q[$];

  int m_idx = 0;
  int m_acc_i [P];
  int m_acc_q [P];

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  fast_square_bb_comb_core dut (
    .clock           (clock),
    .reset           (reset),
    .freq_step       (freq_step),
    .record          (record),
    .i_in            (i_in),
    .q_in            (q_in),
    .i_out           (i_out),
    .q_out           (q_out),
    .data_out_strobe (data_out_strobe)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, compared=%0d", compared);
    $fatal(1, "watchdog");
  end

  // ---------------- reference arithmetic ----------------
  function automatic int avg_next(int a, int x);
    return a + ((x * 16 - a + 8) >>> 4);
  endfunction

  function automatic logic [15:0] rnd_sat(int v);
    int r;
    r = (v + 8) >>> 4;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    return 16'(r);
  endfunction

  function automatic logic [15:0] q_for_slot(int s);
    return 16'(s * 512 - 12288);
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input logic [15:0] i, input logic [15:0] q,
                       input bit fs, input bit rec, input bit rst);
    int ai, aq, step;
    bit stb;
    @(negedge clock);
    i_in = i; q_in = q; freq_step = fs; record = rec; reset = rst;
    if (rst) begin
      for (int k = 0; k < P; k++) begin m_acc_i[k] = 0; m_acc_q[k] = 0; end
      m_idx = 0;
      exp_q.push_back({1'b0, 16'h0000, 16'h0000});
    end else begin
      ai = m_acc_i[m_idx];
      aq = m_acc_q[m_idx];
      if (!rec) begin
        ai = avg_next(ai, int'($signed(i)));
        aq = avg_next(aq, int'($signed(q)));
        m_acc_i[m_idx] = ai;
        m_acc_q[m_idx] = aq;
      end
      step = fs ? 2 : 1;
      stb = (m_idx + step >= P);
      m_idx = (m_idx + step) % P;
      exp_q.push_back({stb, rnd_sat(ai), rnd_sat(aq)});
    end
  endtask

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check2(input string name, input logic [15:0] got,
                        input logic [15:0] lo, input logic [15:0] hi);
    compared++;
    if (got !== lo && got !== hi) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h or %h", name, got, lo, hi);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [32:0] e;
    logic [32:0] got;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        got = {data_out_strobe, i_out, q_out};
        compared++;
        if (got !== e) begin
          mismatched++;
          $display("FAIL sb t=%0t: got stb=%b i=%h q=%h expected stb=%b i=%h q=%h",
                   $time, got[32], got[31:16], got[15:0], e[32], e[31:16], e[15:0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    // Reset held two cycles with nonzero inputs.
    drive(16'h1000, 16'h0100, 0, 0, 1);
    drive(16'h1000, 16'h0100, 0, 0, 1);
    @(posedge clock); #2;
    check("reset_i", i_out, 16'h0000);
    check("reset_q", q_out, 16'h0000);
    check("reset_stb", 16'(data_out_strobe), 16'h0000);

    // Constant step on I, slot-dependent level on Q.
    for (int n = 1; n <= 150 * P; n++) begin
      drive(16'h1000, q_for_slot(m_idx), 0, 0, 0);
      if (n == 1 || n == 31 || n == 32 || n == 33 || n == 65) begin
        @(posedge clock); #2;
        if (n == 1)  check("step_n1", i_out, 16'h0100);
        if (n == 1)  check("first_stb_low", 16'(data_out_strobe), 16'h0000);
        if (n == 31) check("stb_before_wrap", 16'(data_out_strobe), 16'h0000);
        if (n == 32) check("first_stb", 16'(data_out_strobe), 16'h0001);
        if (n == 33) check("step_n2", i_out, 16'h01F0);
        if (n == 65) check("step_n3", i_out, 16'h02D1);
      end
    end
    @(posedge clock); #2;
    check("step_converged", i_out, 16'h1000);

    // One-slot slip at slot 5: the period shortens to 31 samples.
    for (int n = 0; n < 5; n++) drive(16'h1000, q_for_slot(m_idx), 0, 0, 0);
    drive(16'h1000, q_for_slot(m_idx), 1, 0, 0);
    for (int n = 0; n < 24; n++) drive(16'h1000, q_for_slot(m_idx), 0, 0, 0);
    @(posedge clock); #2;
    check("slip_stb_30", 16'(data_out_strobe), 16'h0000);
    drive(16'h1000, q_for_slot(m_idx), 0, 0, 0);
    @(posedge clock); #2;
    check("slip_stb_31", 16'(data_out_strobe), 16'h0001);

    // Freeze, then release toward -0x2000.
    for (int n = 0; n < 2 * P; n++) drive(16'hE000, q_for_slot(m_idx), 0, 1, 0);
    @(posedge clock); #2;
    check("record_hold", i_out, 16'h1000);
    for (int n = 0; n < 150 * P; n++) drive(16'hE000, q_for_slot(m_idx), 0, 0, 0);
    @(posedge clock); #2;
    check2("decay_converged", i_out, 16'hE000, 16'hE001);

    // Full-scale inputs must settle without wrapping.
    for (int n = 0; n < 180 * P; n++) drive(16'h7FFF, 16'h8000, 0, 0, 0);
    @(posedge clock); #2;
    check("sat_pos", i_out, 16'h7FFF);
    check2("sat_neg", q_out, 16'h8000, 16'h8001);

    // Mid-operation reset: next sample lands in a cleared slot 0.
    for (int n = 0; n < 7; n++) drive(16'h7FFF, 16'h8000, 0, 0, 0);
    drive(16'h1000, 16'h0100, 0, 0, 1);
    drive(16'h1000, 16'h0100, 0, 0, 0);
    @(posedge clock); #2;
    check("midreset_i", i_out, 16'h0100);
    check("midreset_q", q_out, 16'h0010);
    for (int n = 0; n < P; n++) drive(16'h0000, 16'h0000, (n % 5) == 2, 0, 0);

    repeat (3) @(posedge clock);
    #3;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
